// File: rtl/edge_pkg.sv
// Shared state encoding and default timing constants for the edge detector / stretcher family.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_e;

  localparam int DEF_HIGH_CYCLES = 8;
  localparam int DEF_GAP_CYCLES  = 2;

  // Reload value for an N-cycle phase; a zero-length phase loads 0 and is never entered.
  function automatic int phase_load(input int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that stops at zero; shared by the HIGH and GAP phases.
module load_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrementing at zero is suppressed so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/edge_stretch.sv
// Pulse-to-level converter: stretches qualified ticks into a fixed-length high pulse
// followed by an optional enforced low gap, with retrigger and drop reporting.
module edge_stretch
  import edge_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int RETRIG      = 1,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ticc,
  output logic level,
  output logic busy,
  output logic drop
);

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(phase_load(HIGH_CYCLES));
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(phase_load(GAP_CYCLES));

  state_e           state_q, state_d;
  logic             level_q, busy_q, drop_q, drop_d;
  logic             tick;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;
  logic [CNT_W-1:0] cnt_unused;

  assign tick = ticc & en;

  load_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_ld_val),
    .dec     (cnt_dec),
    .cnt     (cnt_unused),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    drop_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_ld_val = HIGH_LOAD;
    cnt_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = HIGH;
          cnt_load = 1'b1;
        end
      end
      HIGH: begin
        // A retrigger beats expiry even on the final high cycle.
        if (tick && (RETRIG != 0)) begin
          cnt_load = 1'b1;
        end else begin
          drop_d = tick;
          if (cnt_zero) begin
            if (GAP_CYCLES > 0) begin
              state_d    = GAP;
              cnt_load   = 1'b1;
              cnt_ld_val = GAP_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      GAP: begin
        drop_d = tick;
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered alongside the state so nothing reaches them combinationally from ticc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      drop_q  <= drop_d;
    end
  end

  assign level = level_q;
  assign busy  = busy_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_edge_stretch.sv
// Scoreboard bench for edge_stretch: three configurations driven by directed tick vectors.
module tb_edge_stretch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ticc, en, lvl, bsy, drp;

  always #5 clk = ~clk;

  // dut0: H4 G2 retrigger, dut1: H4 G2 no retrigger, dut2: H1 G0
  edge_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .RETRIG(1), .CNT_W(8)) u_rt (
    .clk(clk), .reset(rst_n), .en(en[0]), .ticc(ticc[0]),
    .level(lvl[0]), .busy(bsy[0]), .drop(drp[0]));
  edge_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .RETRIG(0), .CNT_W(8)) u_nr (
    .clk(clk), .reset(rst_n), .en(en[1]), .ticc(ticc[1]),
    .level(lvl[1]), .busy(bsy[1]), .drop(drp[1]));
  edge_stretch #(.HIGH_CYCLES(1), .GAP_CYCLES(0), .RETRIG(1), .CNT_W(8)) u_g0 (
    .clk(clk), .reset(rst_n), .en(en[2]), .ticc(ticc[2]),
    .level(lvl[2]), .busy(bsy[2]), .drop(drp[2]));

  typedef struct {
    int         sel;
    int         cyc;
    int         tag;
    logic [2:0] exp;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [2:0] mon_got;
  int         errors = 0;
  int         checks = 0;

  function automatic logic [31:0] b(input int n);
    logic [31:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive cycles lo..hi on one DUT; bit c of each mask describes cycle c.
  task automatic run_vec(input int tag, input int sel, input int lo, input int hi,
                         input logic [31:0] tick_m, input logic [31:0] enoff_m,
                         input logic [31:0] lvl_m, input logic [31:0] bsy_m,
                         input logic [31:0] drp_m);
    for (int c = lo; c <= hi; c++) begin
      @(negedge clk);
      ticc      = '0;
      en        = '1;
      ticc[sel] = tick_m[c];
      en[sel]   = ~enoff_m[c];
      sb.push_back('{sel, c + 1, tag, {lvl_m[c+1], bsy_m[c+1], drp_m[c+1]}});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e   = sb.pop_front();
        mon_got = {lvl[mon_e.sel], bsy[mon_e.sel], drp[mon_e.sel]};
        checks++;
        if (mon_got !== mon_e.exp) begin
          errors++;
          $display("FAIL t%0d dut%0d cyc%0d {level,busy,drop}: got %b expected %b",
                   mon_e.tag, mon_e.sel, mon_e.cyc, mon_got, mon_e.exp);
        end
      end
    end
  end

  initial begin
    ticc  = '0;
    en    = '1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_level", lvl[d], 1'b0);
      chk("reset_busy", bsy[d], 1'b0);
      chk("reset_drop", drp[d], 1'b0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // lone tick
    run_vec(1, 0, 1, 24, b(10), '0, rng(11, 14), rng(11, 16), '0);
    // retrigger during HIGH
    run_vec(2, 0, 1, 24, b(10) | b(12), '0, rng(11, 16), rng(11, 18), '0);
    // no retrigger: ticks in HIGH dropped, consecutive drops contiguous
    run_vec(3, 1, 1, 24, b(10) | b(12) | b(13), '0, rng(11, 14), rng(11, 16), rng(13, 14));
    // tick in GAP dropped, tick in following IDLE accepted
    run_vec(4, 0, 1, 27, b(10) | b(15) | b(17), '0, rng(11, 14) | rng(18, 21),
            rng(11, 16) | rng(18, 23), b(16));
    // no gap: back-to-back pulses, ticks with en low ignored silently
    run_vec(6, 2, 1, 20, b(10) | b(12) | b(14), b(14), b(11) | b(13), b(11) | b(13), '0);
    // retrigger on the last high cycle beats expiry
    run_vec(7, 0, 1, 24, b(10) | b(14), '0, rng(11, 18), rng(11, 20), '0);
    // en low does not abort the pulse and suppresses drop
    run_vec(8, 0, 1, 24, b(10) | b(12), rng(11, 16), rng(11, 14), rng(11, 16), '0);
    // two ticks in GAP give a two-cycle drop
    run_vec(9, 0, 1, 24, b(10) | b(15) | b(16), '0, rng(11, 14), rng(11, 16), rng(16, 17));

    // asynchronous reset in the middle of a pulse
    run_vec(5, 0, 1, 11, b(10), '0, rng(11, 12), rng(11, 12), '0);
    @(negedge clk);
    ticc = '0;
    chk("pre_reset_level", lvl[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_level", lvl[0], 1'b0);
    chk("async_reset_busy", bsy[0], 1'b0);
    chk("async_reset_drop", drp[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(5, 0, 1, 27, b(20), '0, rng(21, 24), rng(21, 26), '0);

    @(negedge clk);
    ticc = '0;
    en   = '1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
